mandel_engine_scheduler: RTL and testbench
==========================================

Name: mandel_engine_scheduler

Overview:
- Frame-level scheduler that shares NUM_ENGINES Mandelbrot iteration engines across the pixel raster.
- Scans x/y, dispatches each pixel to a free engine and records each engine's pixel coordinates.
- Arbitrates finished results round-robin onto one valid/ready plot stream for the VGA/framebuffer writer.
- Sits between the top-level frame control and the engine array / plot sink.

Parameters:
NUM_ENGINES, 4, number of engines (1..8)
MAX_WIDTH, 320, pixels per line; x runs 0..MAX_WIDTH-1
MAX_HEIGHT, 240, lines per frame; y runs 0..MAX_HEIGHT-1
ITER_W, 12, width of the iteration limit and result count

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high; clears all state
start  in  1  begin a frame; sampled only in IDLE
max_iter  in  ITER_W  iteration limit; latched when start is accepted
busy  out  1  high from start acceptance until frame_done
frame_done  out  1  one-cycle pulse when the last pixel of the frame is accepted by the sink
eng_start  out  NUM_ENGINES  one-hot dispatch pulse, one cycle
eng_x  out  10  x of the dispatched pixel, valid with eng_start
eng_y  out  10  y of the dispatched pixel, valid with eng_start
eng_max_iter  out  ITER_W  latched max_iter, stable for the whole frame
eng_done  in  NUM_ENGINES  engine result ready; held until acked
eng_count  in  NUM_ENGINES*ITER_W  per-engine result count; engine i uses bits [i*ITER_W +: ITER_W]
eng_ack  out  NUM_ENGINES  one-hot one-cycle pulse; result consumed, engine freed
plot_valid  out  1  plot output register holds a result
plot_ready  in  1  sink accepts when plot_valid && plot_ready
plot_x  out  10  pixel x of the plot result
plot_y  out  10  pixel y of the plot result
plot_count  out  ITER_W  iteration count of the plot result

Behaviour:
- All outputs are registered. Reset value is 0 for every output, the inflight mask, coordinate table, raster counters and both RR pointers; state is IDLE.
- States: IDLE -> RUN on start; RUN -> DRAIN when the last pixel (MAX_WIDTH-1, MAX_HEIGHT-1) is dispatched; DRAIN -> DONE when the inflight mask is 0, plot_valid is 0 and no ack is pending; DONE -> IDLE after one cycle, pulsing frame_done. Holding start high restarts the frame from IDLE.
- start outside IDLE is ignored. max_iter changes during a frame have no effect.
- Dispatch (RUN only): each cycle, if any engine has inflight=0, grant the first free engine searching from rr_d upward, wrapping modulo NUM_ENGINES. Grant sets inflight[i], stores (x,y) in table[i], pulses eng_start[i] next cycle with eng_x/eng_y, sets rr_d=i+1 mod N and advances the raster.
- Maximum rate is one dispatch per cycle. The first eng_start appears in the cycle after start is sampled.
- Raster order: x increments; at MAX_WIDTH-1, x wraps to 0 and y increments. No pixel is skipped or repeated.
- Write-back: the output register is loadable when plot_valid==0 or (plot_valid && plot_ready). If loadable and some eng_done[i] && inflight[i], grant from rr_w round-robin.
- On a write-back grant, load plot_x/plot_y from table[i] and plot_count from eng_count[i], set plot_valid, pulse eng_ack[i] the same cycle, clear inflight[i] and set rr_w=i+1.
- Full-throughput back-to-back handoff is allowed.
- An engine freed by ack in cycle t is dispatchable no earlier than cycle t+1. Dispatch and write-back to different engines in the same cycle are both serviced.
- While plot_valid && !plot_ready, plot_x/plot_y/plot_count are held stable and no eng_ack is issued.
- eng_done without inflight is ignored.
- Reset mid-frame aborts immediately: no further eng_start, eng_ack or plot_valid. Engines share the same reset.

Test Plan:
- N=1, MAX_WIDTH=4, MAX_HEIGHT=2, engine fixed latency 3 cycles, counts = x+y, plot_ready=1 -> 8 plots in raster order (0,0)..(3,1) with correct counts; one frame_done; busy low afterwards.
- N=4, latencies 7/2/5/3 cycles -> out-of-order plots; every (x,y) appears exactly once with matching count; never two eng_start bits in one cycle.
- plot_ready low for 10 cycles mid-frame -> plot_valid and data held stable, no eng_ack; dispatch stalls once all 4 engines are inflight; everything resumes when ready rises.
- N=4, all four eng_done rise together, plot_ready=1 -> eng_ack order 0,1,2,3 on consecutive cycles. Next simultaneous batch starts from rr_w.
- Assert start during RUN and change max_iter mid-frame -> ignored; eng_max_iter keeps the value latched at the original start.
- Assert reset at pixel 5 of a frame -> next cycle all outputs are 0 and state is IDLE; a new start rescans from (0,0).

Source files
------------

// File: rtl/mandel_engine_scheduler.sv
// mandel_engine_scheduler
//
// Frame-level scheduler sharing NUM_ENGINES Mandelbrot iteration engines across
// the pixel raster. Pixels are scanned in raster order and handed to the first
// free engine, searching round-robin. Finished engine results are collected
// round-robin into a single registered valid/ready plot stream.
//
// Ports
//   clock, reset      system clock; synchronous active-high reset
//   start, max_iter   frame request and iteration limit (taken in IDLE only)
//   busy, frame_done  frame in progress / one-cycle end-of-frame pulse
//   eng_start         one-hot dispatch pulse, with eng_x / eng_y
//   eng_max_iter      iteration limit latched for the whole frame
//   eng_done          per-engine result ready, held until eng_ack
//   eng_count         per-engine result count, engine i at [i*ITER_W +: ITER_W]
//   eng_ack           one-hot pulse: result consumed, engine freed
//   plot_valid/ready  plot stream handshake
//   plot_x/y/count    pixel coordinates and iteration count of the plot result
module mandel_engine_scheduler #(
  parameter int unsigned NUM_ENGINES = 4,
  parameter int unsigned MAX_WIDTH   = 320,
  parameter int unsigned MAX_HEIGHT  = 240,
  parameter int unsigned ITER_W      = 12
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ITER_W-1:0]             max_iter,
  output logic                          busy,
  output logic                          frame_done,
  output logic [NUM_ENGINES-1:0]        eng_start,
  output logic [9:0]                    eng_x,
  output logic [9:0]                    eng_y,
  output logic [ITER_W-1:0]             eng_max_iter,
  input  logic [NUM_ENGINES-1:0]        eng_done,
  input  logic [NUM_ENGINES*ITER_W-1:0] eng_count,
  output logic [NUM_ENGINES-1:0]        eng_ack,
  output logic                          plot_valid,
  input  logic                          plot_ready,
  output logic [9:0]                    plot_x,
  output logic [9:0]                    plot_y,
  output logic [ITER_W-1:0]             plot_count
);

  localparam int unsigned RrW   = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [9:0]  LastX = 10'(MAX_WIDTH - 1);
  localparam logic [9:0]  LastY = 10'(MAX_HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic                   busy_q, busy_d;
  logic                   frame_done_q, frame_done_d;
  logic [NUM_ENGINES-1:0] inflight_q, inflight_d;
  logic [9:0]             tab_x_q [NUM_ENGINES];
  logic [9:0]             tab_y_q [NUM_ENGINES];
  logic [9:0]             x_q, y_q;
  logic [RrW-1:0]         disp_rr_q, wb_rr_q;
  logic [NUM_ENGINES-1:0] eng_start_q, eng_ack_q;
  logic [9:0]             eng_x_q, eng_y_q;
  logic [ITER_W-1:0]      max_iter_q;
  logic                   plot_valid_q;
  logic [9:0]             plot_x_q, plot_y_q;
  logic [ITER_W-1:0]      plot_count_q;

  logic                   accept_start, disp_en, disp_go, last_pix;
  logic                   wb_load, wb_go, drained;
  logic [RrW-1:0]         disp_idx, wb_idx;
  logic [NUM_ENGINES-1:0] disp_req, wb_req;

  // First requester at or after ptr, wrapping modulo NUM_ENGINES.
  // Returns {found, index}.
  function automatic logic [RrW:0] rr_pick(input logic [NUM_ENGINES-1:0] req,
                                           input logic [RrW-1:0]         ptr);
    logic [RrW:0]   res;
    logic [RrW-1:0] cand;
    int unsigned    j;
    res  = '0;
    cand = '0;
    j    = 0;
    for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
      j    = (32'(ptr) + k) % NUM_ENGINES;
      cand = RrW'(j);
      if (!res[RrW] && req[cand]) begin
        res = {1'b1, cand};
      end
    end
    return res;
  endfunction

  function automatic logic [RrW-1:0] rr_next(input logic [RrW-1:0] idx);
    return (32'(idx) == NUM_ENGINES - 1) ? '0 : idx + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Dispatch and write-back arbitration
  // ---------------------------------------------------------------------------
  // The start-accept cycle already dispatches pixel (0,0) so that the first
  // eng_start appears right after start is taken.
  assign accept_start = (state_q == StIdle) && start;
  assign disp_en      = (state_q == StRun) || accept_start;
  assign last_pix     = (x_q == LastX) && (y_q == LastY);
  assign disp_req     = disp_en ? ~inflight_q : '0;

  assign {disp_go, disp_idx} = rr_pick(disp_req, disp_rr_q);

  // Output register may be refilled when empty or being drained this cycle.
  assign wb_load = !plot_valid_q || plot_ready;
  assign wb_req  = wb_load ? (eng_done & inflight_q) : '0;

  assign {wb_go, wb_idx} = rr_pick(wb_req, wb_rr_q);

  // Both updates act on distinct engines: dispatch only picks free ones,
  // write-back only inflight ones. A freed engine is seen free next cycle.
  always_comb begin
    inflight_d = inflight_q;
    if (disp_go) begin
      inflight_d[disp_idx] = 1'b1;
    end
    if (wb_go) begin
      inflight_d[wb_idx] = 1'b0;
    end
  end

  assign drained = (inflight_q == '0) && !plot_valid_q && (eng_ack_q == '0);

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (disp_go && last_pix) ? StDrain : StRun;
        end
      end
      StRun: begin
        if (disp_go && last_pix) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (drained) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_comb begin
    busy_d       = (state_d == StRun) || (state_d == StDrain);
    frame_done_d = (state_d == StDone);
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      inflight_q   <= '0;
      x_q          <= '0;
      y_q          <= '0;
      disp_rr_q    <= '0;
      wb_rr_q      <= '0;
      eng_start_q  <= '0;
      eng_ack_q    <= '0;
      eng_x_q      <= '0;
      eng_y_q      <= '0;
      max_iter_q   <= '0;
      plot_valid_q <= 1'b0;
      plot_x_q     <= '0;
      plot_y_q     <= '0;
      plot_count_q <= '0;
      for (int i = 0; i < NUM_ENGINES; i++) begin
        tab_x_q[i] <= '0;
        tab_y_q[i] <= '0;
      end
    end else begin
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      inflight_q   <= inflight_d;
      eng_start_q  <= '0;
      eng_ack_q    <= '0;

      if (accept_start) begin
        max_iter_q <= max_iter;
      end

      if (disp_go) begin
        tab_x_q[disp_idx]     <= x_q;
        tab_y_q[disp_idx]     <= y_q;
        eng_start_q[disp_idx] <= 1'b1;
        eng_x_q               <= x_q;
        eng_y_q               <= y_q;
        disp_rr_q             <= rr_next(disp_idx);
        // Raster wraps back to (0,0) after the last pixel, ready for the next frame.
        if (x_q == LastX) begin
          x_q <= '0;
          y_q <= (y_q == LastY) ? '0 : y_q + 10'd1;
        end else begin
          x_q <= x_q + 10'd1;
        end
      end

      if (wb_go) begin
        plot_valid_q      <= 1'b1;
        plot_x_q          <= tab_x_q[wb_idx];
        plot_y_q          <= tab_y_q[wb_idx];
        plot_count_q      <= eng_count[32'(wb_idx) * ITER_W +: ITER_W];
        eng_ack_q[wb_idx] <= 1'b1;
        wb_rr_q           <= rr_next(wb_idx);
      end else if (plot_valid_q && plot_ready) begin
        plot_valid_q <= 1'b0;
      end
    end
  end

  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign eng_start    = eng_start_q;
  assign eng_x        = eng_x_q;
  assign eng_y        = eng_y_q;
  assign eng_max_iter = max_iter_q;
  assign eng_ack      = eng_ack_q;
  assign plot_valid   = plot_valid_q;
  assign plot_x       = plot_x_q;
  assign plot_y       = plot_y_q;
  assign plot_count   = plot_count_q;

endmodule

// File: tb/tb_mandel_engine_scheduler.sv
// Testbench for mandel_engine_scheduler: behavioural engine array, raster and
// plot scoreboard, backpressure, simultaneous-done arbitration and reset abort.
module tb_mandel_engine_scheduler;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int H    = 4;
  localparam int IW   = 12;
  localparam int NPIX = W * H;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [IW-1:0]   max_iter = '0;
  logic            busy, frame_done;
  logic [N-1:0]    eng_start, eng_ack, eng_done;
  logic [9:0]      eng_x, eng_y, plot_x, plot_y;
  logic [IW-1:0]   eng_max_iter, plot_count;
  logic [N*IW-1:0] eng_count;
  logic            plot_valid;
  logic            plot_ready = 1'b1;

  always #5 clock = ~clock;

  mandel_engine_scheduler #(
    .NUM_ENGINES(N),
    .MAX_WIDTH  (W),
    .MAX_HEIGHT (H),
    .ITER_W     (IW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .max_iter    (max_iter),
    .busy        (busy),
    .frame_done  (frame_done),
    .eng_start   (eng_start),
    .eng_x       (eng_x),
    .eng_y       (eng_y),
    .eng_max_iter(eng_max_iter),
    .eng_done    (eng_done),
    .eng_count   (eng_count),
    .eng_ack     (eng_ack),
    .plot_valid  (plot_valid),
    .plot_ready  (plot_ready),
    .plot_x      (plot_x),
    .plot_y      (plot_y),
    .plot_count  (plot_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Result an engine reports for a pixel under a given iteration limit.
  function automatic logic [IW-1:0] pix_count(input logic [9:0] x, input logic [9:0] y,
                                               input logic [IW-1:0] mi);
    return IW'(32'(x) * 3 + 32'(y) * 17 + 5) ^ mi;
  endfunction

  // Expected coordinates of the i-th pixel of a frame, packed {x, y}.
  function automatic logic [19:0] raster_xy(input int i);
    return {10'(i % W), 10'(i / W)};
  endfunction

  // ---------------------------------------------------------------------------
  // Engine array model: start -> latency -> done held until ack
  // ---------------------------------------------------------------------------
  int            lat [N];
  logic          gate = 1'b1;
  logic [N-1:0]  e_busy, e_done;
  int            e_cnt [N];
  logic [IW-1:0] e_res [N];

  always @(posedge clock) begin
    if (reset) begin
      e_busy <= '0;
      e_done <= '0;
      for (int i = 0; i < N; i++) begin
        e_cnt[i] <= 0;
        e_res[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (eng_ack[i]) begin
          e_busy[i] <= 1'b0;
          e_done[i] <= 1'b0;
        end else if (eng_start[i]) begin
          e_busy[i] <= 1'b1;
          e_cnt[i]  <= lat[i];
          e_res[i]  <= pix_count(eng_x, eng_y, eng_max_iter);
        end else if (e_busy[i] && !e_done[i]) begin
          if (e_cnt[i] == 0) e_done[i] <= 1'b1;
          else e_cnt[i] <= e_cnt[i] - 1;
        end
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_eng
    assign eng_done[g]           = e_done[g] & gate;
    assign eng_count[g*IW +: IW] = e_res[g];
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard (sampled on the falling edge)
  // ---------------------------------------------------------------------------
  int            cyc = 0;
  int            n_disp = 0, n_plot = 0, n_fdone = 0, n_ack = 0;
  int            disp_base = 0, plot_base = 0, fd_base = 0, frame_id = 0;
  logic [IW-1:0] exp_mi = '0;
  int            seen_frame [H][W];
  int            ack_idx [1024];
  int            ack_cyc [1024];
  logic          prev_stall = 1'b0;
  logic [9:0]    hold_x, hold_y;
  logic [IW-1:0] hold_c;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", plot_valid, 1);
        check_eq("hold_data", {plot_x, plot_y, plot_count}, {hold_x, hold_y, hold_c});
        check_eq("hold_no_ack", eng_ack, 0);
      end
      if (eng_start != '0) begin
        check_eq("start_onehot", $countones(eng_start), 1);
        check_eq("disp_xy", {eng_x, eng_y}, raster_xy(n_disp - disp_base));
        check_eq("disp_max_iter", eng_max_iter, exp_mi);
        check_eq("disp_busy", busy, 1);
        n_disp <= n_disp + 1;
      end
      if (eng_ack != '0) begin
        check_eq("ack_onehot", $countones(eng_ack), 1);
        for (int i = 0; i < N; i++) begin
          if (eng_ack[i]) ack_idx[n_ack & 1023] <= i;
        end
        ack_cyc[n_ack & 1023] <= cyc;
        n_ack <= n_ack + 1;
      end
      if (frame_done) n_fdone <= n_fdone + 1;
      if (plot_valid && plot_ready) begin
        check_eq("plot_count", plot_count, pix_count(plot_x, plot_y, exp_mi));
        check_eq("plot_range", (plot_x < W) && (plot_y < H), 1);
        if ((plot_x < W) && (plot_y < H)) begin
          check_eq("plot_unique", seen_frame[int'(plot_y)][int'(plot_x)] == frame_id, 0);
          seen_frame[int'(plot_y)][int'(plot_x)] <= frame_id;
        end
        n_plot <= n_plot + 1;
      end
      prev_stall <= plot_valid && !plot_ready;
      hold_x     <= plot_x;
      hold_y     <= plot_y;
      hold_c     <= plot_count;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus tasks
  // ---------------------------------------------------------------------------
  task automatic check_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_frame_done"}, frame_done, 0);
    check_eq({tag, "_eng_start"}, eng_start, 0);
    check_eq({tag, "_eng_ack"}, eng_ack, 0);
    check_eq({tag, "_plot_valid"}, plot_valid, 0);
    check_eq({tag, "_eng_regs"}, {eng_x, eng_y, eng_max_iter}, 0);
    check_eq({tag, "_plot_regs"}, {plot_x, plot_y, plot_count}, 0);
  endtask

  task automatic begin_frame(input logic [IW-1:0] mi);
    frame_id++;
    disp_base = n_disp;
    plot_base = n_plot;
    fd_base   = n_fdone;
    exp_mi    = mi;
    @(posedge clock); #1;
    start    = 1'b1;
    max_iter = mi;
    @(posedge clock); #1;
    check_eq("first_start", eng_start != '0, 1);
    check_eq("first_xy", {eng_x, eng_y}, 0);
    check_eq("busy_on", busy, 1);
    start = 1'b0;
  endtask

  // mode 0: random ready plus start/max_iter noise, 1: 10-cycle stall, 2: ready=1
  task automatic finish_frame(input int mode);
    bit done;
    int dsnap;
    done  = 0;
    dsnap = 0;
    for (int t = 1; t < 4000 && !done; t++) begin
      @(posedge clock); #1;
      case (mode)
        0: begin
          plot_ready = ($urandom_range(0, 3) != 0);
          if (t >= 3 && t < 12) begin
            start    = 1'($urandom_range(0, 1));
            max_iter = IW'($urandom);
          end else begin
            start = 1'b0;
          end
        end
        1: begin
          plot_ready = !(t >= 15 && t < 25);
          if (t == 22) dsnap = n_disp;
          if (t == 24) check_eq("stall_valid", plot_valid, 1);
          if (t == 25) check_eq("stall_no_disp", n_disp, dsnap);
        end
        default: plot_ready = 1'b1;
      endcase
      if (n_fdone != fd_base) begin
        done = 1;
        check_eq("fd_pulse", frame_done, 0);
      end
    end
    check_eq("frame_timeout", done, 1);
    start      = 1'b0;
    plot_ready = 1'b1;
    @(posedge clock); #1;
    check_eq("busy_off", busy, 0);
    check_eq("n_dispatch", n_disp - disp_base, NPIX);
    check_eq("n_plot", n_plot - plot_base, NPIX);
    check_eq("n_frame_done", n_fdone - fd_base, 1);
  endtask

  // Wait until every engine holds a result, then open the done gate and
  // expect acks 0,1,2,3 on consecutive cycles.
  task automatic release_batch(input string tag);
    bit ok;
    int a0;
    ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(posedge clock); #1;
      ok = (e_done == '1);
    end
    check_eq({tag, "_all_done"}, ok, 1);
    a0   = n_ack;
    gate = 1'b1;
    ok   = 0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(posedge clock); #1;
      ok = (n_ack - a0 >= 4);
    end
    gate = 1'b0;
    check_eq({tag, "_acks"}, ok, 1);
    for (int k = 0; k < 4; k++) begin
      check_eq({tag, "_ack_id"}, ack_idx[(a0 + k) & 1023], k);
      check_eq({tag, "_ack_cyc"}, ack_cyc[(a0 + k) & 1023] - ack_cyc[a0 & 1023], k);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit ok;
    for (int i = 0; i < N; i++) lat[i] = 2;

    repeat (3) @(posedge clock);
    #1;
    check_zero("rst");
    reset = 1'b0;
    @(posedge clock); #1;
    check_zero("idle");

    // Unequal fixed latencies, random backpressure, start/max_iter noise.
    lat[0] = 7; lat[1] = 2; lat[2] = 5; lat[3] = 3;
    begin_frame(12'h0A5);
    finish_frame(0);

    // Random latencies with a long sink stall mid-frame.
    for (int i = 0; i < N; i++) lat[i] = $urandom_range(0, 3);
    begin_frame(IW'($urandom));
    finish_frame(1);

    // Simultaneous results from a fresh reset: both pointers start at 0.
    do_reset();
    for (int i = 0; i < N; i++) lat[i] = 5;
    gate = 1'b0;
    begin_frame(12'h123);
    release_batch("batch1");
    release_batch("batch2");
    gate = 1'b1;
    finish_frame(2);

    // Reset a few pixels into a frame, then rescan from (0,0).
    for (int i = 0; i < N; i++) lat[i] = $urandom_range(1, 4);
    begin_frame(12'h7E0);
    ok = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(posedge clock); #1;
      ok = (n_disp - disp_base >= 5);
    end
    check_eq("abort_reach5", ok, 1);
    reset = 1'b1;
    @(posedge clock); #1;
    check_zero("abort");
    @(posedge clock); #1;
    check_eq("abort_engines", e_done | e_busy, 0);
    reset = 1'b0;
    @(posedge clock); #1;
    check_zero("abort_idle");
    begin_frame(12'h055);
    finish_frame(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
